// File: rtl/tile_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tile_sequencer
//  Purpose  : Top-level tile scheduler for the systolic array. For each tile
//             it launches the weight-load, input-feed and output-store memory
//             controllers one after another, waits for each controller's done,
//             drains the array pipeline between feed and store, then advances
//             every base address by its stride. Reports done after the last
//             tile, or aborted if the job is cancelled.
//  Ports    : clk, reset (async, active-low)
//             start, abort                       job control
//             wt/in/out_base, wt/in/out_stride   job addresses (captured)
//             rows_num, cols_num, tile_num       job shape (captured)
//             wt/in/out_done                     controller done levels
//             wt/in/out_active                   one-cycle phase launches
//             wt/in/out_addr                     current tile base addresses
//             rows/cols_enabled_num, tile_idx    current job shape / position
//             busy, done, aborted                job status
//  Revision : 1.0  initial release
// ============================================================================
module tile_sequencer #(
    parameter int ADDR_WIDTH   = 8,
    parameter int WIDTH_HEIGHT = 16,
    parameter int TILE_WIDTH   = 8,
    localparam int c_CW        = $clog2(WIDTH_HEIGHT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] wt_base,
    input  logic [ADDR_WIDTH-1:0] in_base,
    input  logic [ADDR_WIDTH-1:0] out_base,
    input  logic [ADDR_WIDTH-1:0] wt_stride,
    input  logic [ADDR_WIDTH-1:0] in_stride,
    input  logic [ADDR_WIDTH-1:0] out_stride,
    input  logic [c_CW-1:0]       rows_num,
    input  logic [c_CW-1:0]       cols_num,
    input  logic [TILE_WIDTH-1:0] tile_num,
    input  logic                  wt_done,
    input  logic                  in_done,
    input  logic                  out_done,
    output logic                  wt_active,
    output logic                  in_active,
    output logic                  out_active,
    output logic [ADDR_WIDTH-1:0] wt_addr,
    output logic [ADDR_WIDTH-1:0] in_addr,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [c_CW-1:0]       rows_enabled_num,
    output logic [c_CW-1:0]       cols_enabled_num,
    output logic [TILE_WIDTH-1:0] tile_idx,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted
);

    // Drain counter counts 2*WIDTH_HEIGHT-2 down to 0, i.e. 2*WIDTH_HEIGHT-1 cycles.
    localparam int              c_DW         = $clog2(2 * WIDTH_HEIGHT);
    localparam logic [c_DW-1:0] c_DRAIN_LAST = c_DW'(2 * WIDTH_HEIGHT - 2);
    localparam logic [1:0]      c_BLANK_INIT = 2'd2;

    localparam logic [3:0] c_IDLE    = 4'd0;
    localparam logic [3:0] c_W_ISSUE = 4'd1;
    localparam logic [3:0] c_W_WAIT  = 4'd2;
    localparam logic [3:0] c_F_ISSUE = 4'd3;
    localparam logic [3:0] c_F_WAIT  = 4'd4;
    localparam logic [3:0] c_DRAIN   = 4'd5;
    localparam logic [3:0] c_S_ISSUE = 4'd6;
    localparam logic [3:0] c_S_WAIT  = 4'd7;
    localparam logic [3:0] c_NEXT    = 4'd8;
    localparam logic [3:0] c_FINISH  = 4'd9;

    logic [3:0]            r_state;
    logic [3:0]            w_state_next;
    logic                  w_accept;
    logic                  w_advance;
    logic                  w_abort;
    logic                  w_blank_clear;

    logic [1:0]            r_blank;
    logic [c_DW-1:0]       r_drain;
    logic [ADDR_WIDTH-1:0] r_wt_stride;
    logic [ADDR_WIDTH-1:0] r_in_stride;
    logic [ADDR_WIDTH-1:0] r_out_stride;
    logic [TILE_WIDTH-1:0] r_tile_num;

    logic                  r_wt_active;
    logic                  r_in_active;
    logic                  r_out_active;
    logic [ADDR_WIDTH-1:0] r_wt_addr;
    logic [ADDR_WIDTH-1:0] r_in_addr;
    logic [ADDR_WIDTH-1:0] r_out_addr;
    logic [c_CW-1:0]       r_rows;
    logic [c_CW-1:0]       r_cols;
    logic [TILE_WIDTH-1:0] r_tile_idx;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_aborted;

    assign w_abort       = abort && (r_state != c_IDLE);
    // A controller's done may still be high from its previous run, so it is
    // only trusted once the blanking counter has expired.
    assign w_blank_clear = (r_blank == 2'd0);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_advance    = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (start && !abort) begin
                    w_state_next = c_W_ISSUE;
                    w_accept     = 1'b1;
                end
            end
            c_W_ISSUE: w_state_next = c_W_WAIT;
            c_W_WAIT:  if (w_blank_clear && wt_done)  w_state_next = c_F_ISSUE;
            c_F_ISSUE: w_state_next = c_F_WAIT;
            c_F_WAIT:  if (w_blank_clear && in_done)  w_state_next = c_DRAIN;
            c_DRAIN:   if (r_drain == '0)             w_state_next = c_S_ISSUE;
            c_S_ISSUE: w_state_next = c_S_WAIT;
            c_S_WAIT:  if (w_blank_clear && out_done) w_state_next = c_NEXT;
            c_NEXT: begin
                if (r_tile_idx == r_tile_num) begin
                    w_state_next = c_FINISH;
                end else begin
                    w_state_next = c_W_ISSUE;
                    w_advance    = 1'b1;
                end
            end
            c_FINISH:  w_state_next = c_IDLE;
            default:   w_state_next = c_IDLE;
        endcase
        // Abort overrides every other decision, including NEXT/FINISH.
        if (w_abort) begin
            w_state_next = c_IDLE;
            w_accept     = 1'b0;
            w_advance    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Datapath and registered outputs. Status outputs are decoded from the
    // next state so they line up with the state they describe.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_blank      <= '0;
            r_drain      <= '0;
            r_wt_stride  <= '0;
            r_in_stride  <= '0;
            r_out_stride <= '0;
            r_tile_num   <= '0;
            r_wt_active  <= 1'b0;
            r_in_active  <= 1'b0;
            r_out_active <= 1'b0;
            r_wt_addr    <= '0;
            r_in_addr    <= '0;
            r_out_addr   <= '0;
            r_rows       <= '0;
            r_cols       <= '0;
            r_tile_idx   <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
        end else begin
            r_wt_active  <= (w_state_next == c_W_ISSUE);
            r_in_active  <= (w_state_next == c_F_ISSUE);
            r_out_active <= (w_state_next == c_S_ISSUE);
            r_busy       <= (w_state_next != c_IDLE);
            r_done       <= (w_state_next == c_FINISH);
            r_aborted    <= w_abort;

            if ((r_state == c_W_ISSUE) || (r_state == c_F_ISSUE) ||
                (r_state == c_S_ISSUE)) begin
                r_blank <= c_BLANK_INIT;
            end else if (!w_blank_clear) begin
                r_blank <= r_blank - 2'd1;
            end

            if ((w_state_next == c_DRAIN) && (r_state != c_DRAIN)) begin
                r_drain <= c_DRAIN_LAST;
            end else if ((r_state == c_DRAIN) && (r_drain != '0)) begin
                r_drain <= r_drain - c_DW'(1);
            end

            if (w_accept) begin
                r_wt_addr    <= wt_base;
                r_in_addr    <= in_base;
                r_out_addr   <= out_base;
                r_wt_stride  <= wt_stride;
                r_in_stride  <= in_stride;
                r_out_stride <= out_stride;
                r_rows       <= rows_num;
                r_cols       <= cols_num;
                r_tile_num   <= tile_num;
                r_tile_idx   <= '0;
            end else if (w_advance) begin
                // Modulo-2^ADDR_WIDTH wrap is intentional and silent.
                r_wt_addr    <= r_wt_addr  + r_wt_stride;
                r_in_addr    <= r_in_addr  + r_in_stride;
                r_out_addr   <= r_out_addr + r_out_stride;
                r_tile_idx   <= r_tile_idx + TILE_WIDTH'(1);
            end
        end
    end

    assign wt_active        = r_wt_active;
    assign in_active        = r_in_active;
    assign out_active       = r_out_active;
    assign wt_addr          = r_wt_addr;
    assign in_addr          = r_in_addr;
    assign out_addr         = r_out_addr;
    assign rows_enabled_num = r_rows;
    assign cols_enabled_num = r_cols;
    assign tile_idx         = r_tile_idx;
    assign busy             = r_busy;
    assign done             = r_done;
    assign aborted          = r_aborted;

endmodule
`default_nettype wire

// File: tb/tb_tile_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_tile_sequencer
//  Purpose  : Directed self-checking bench for tile_sequencer. Controller
//             responders return done four cycles after each active pulse.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tile_sequencer;
    localparam int AW = 8;
    localparam int WH = 16;
    localparam int TW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] wt_base = '0, in_base = '0, out_base = '0;
    logic [AW-1:0] wt_stride = '0, in_stride = '0, out_stride = '0;
    logic [CW-1:0] rows_num = '0, cols_num = '0;
    logic [TW-1:0] tile_num = '0;
    logic          wt_done = 1'b0, in_done = 1'b0, out_done = 1'b0;
    logic          wt_active, in_active, out_active;
    logic [AW-1:0] wt_addr, in_addr, out_addr;
    logic [CW-1:0] rows_enabled_num, cols_enabled_num;
    logic [TW-1:0] tile_idx;
    logic          busy, done, aborted;

    tile_sequencer #(.ADDR_WIDTH(AW), .WIDTH_HEIGHT(WH), .TILE_WIDTH(TW)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .wt_base(wt_base), .in_base(in_base), .out_base(out_base),
        .wt_stride(wt_stride), .in_stride(in_stride), .out_stride(out_stride),
        .rows_num(rows_num), .cols_num(cols_num), .tile_num(tile_num),
        .wt_done(wt_done), .in_done(in_done), .out_done(out_done),
        .wt_active(wt_active), .in_active(in_active), .out_active(out_active),
        .wt_addr(wt_addr), .in_addr(in_addr), .out_addr(out_addr),
        .rows_enabled_num(rows_enabled_num), .cols_enabled_num(cols_enabled_num),
        .tile_idx(tile_idx), .busy(busy), .done(done), .aborted(aborted)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_c = 0;
    int wt_tmr = -1, in_tmr = -1, out_tmr = -1;
    bit hold_wt = 1'b0;
    int n_wt, n_in, n_out, n_done, n_abt;
    int wt_c[8], in_c[8], out_c[8];
    logic [AW-1:0] wt_a[8], in_a[8], out_a[8];
    logic [TW-1:0] ti[8];
    int done_c, in_done_c;

    task automatic clear_log();
        n_wt = 0; n_in = 0; n_out = 0; n_done = 0; n_abt = 0;
        done_c = -1; in_done_c = -1;
        for (int i = 0; i < 8; i++) begin
            wt_c[i] = -1; in_c[i] = -1; out_c[i] = -1;
            wt_a[i] = '0; in_a[i] = '0; out_a[i] = '0; ti[i] = '0;
        end
    endtask

    // One clock cycle: sample outputs at the falling edge, log events, then
    // drive the controller done inputs for this cycle.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (wt_active) begin
            if (n_wt < 8) begin wt_c[n_wt] = cyc; wt_a[n_wt] = wt_addr; ti[n_wt] = tile_idx; end
            n_wt++;
        end
        if (in_active) begin
            if (n_in < 8) begin in_c[n_in] = cyc; in_a[n_in] = in_addr; end
            n_in++;
        end
        if (out_active) begin
            if (n_out < 8) begin out_c[n_out] = cyc; out_a[n_out] = out_addr; end
            n_out++;
        end
        if (done) begin n_done++; done_c = cyc; end
        if (aborted) n_abt++;
        if (wt_tmr >= 0) wt_tmr--;
        if (in_tmr >= 0) in_tmr--;
        if (out_tmr >= 0) out_tmr--;
        if (wt_active) wt_tmr = 4;
        if (in_active) in_tmr = 4;
        if (out_active) out_tmr = 4;
        wt_done  = hold_wt || (wt_tmr == 0);
        in_done  = (in_tmr == 0);
        out_done = (out_tmr == 0);
        if (in_done) in_done_c = cyc;
    endtask

    task automatic launch(input logic [AW-1:0] wb, ib, ob, ws, is, os,
                          input logic [TW-1:0] tn);
        wt_base = wb; in_base = ib; out_base = ob;
        wt_stride = ws; in_stride = is; out_stride = os;
        rows_num = 4'd3; cols_num = 4'd5; tile_num = tn;
        start = 1'b1;
        start_c = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic run_until_done(input int budget);
        int k;
        k = 0;
        while (n_done == 0 && n_abt == 0 && k < budget) begin
            tick();
            k++;
        end
        checks++;
        if (n_done == 0) begin
            errors++;
            $display("FAIL job_timeout got done_count %0d exp 1 within %0d cycles", n_done, budget);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({wt_active, in_active, out_active, busy, done, aborted} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 000000", {wt_active, in_active, out_active, busy, done, aborted});
        end
        checks++;
        if ({wt_addr, in_addr, out_addr, tile_idx, rows_enabled_num, cols_enabled_num} !== '0) begin
            errors++;
            $display("FAIL reset_data got %h exp 0", {wt_addr, in_addr, out_addr, tile_idx, rows_enabled_num, cols_enabled_num});
        end
        reset = 1'b1;
        clear_log();
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0 || n_wt != 0) begin
            errors++;
            $display("FAIL reset_idle got busy %b wt_pulses %0d exp 0 0", busy, n_wt);
        end
    endtask

    task automatic test_single_tile();
        int s;
        clear_log();
        launch(8'h10, 8'h40, 8'h80, 8'h00, 8'h00, 8'h00, 8'd0);
        s = start_c;
        run_until_done(200);
        tick();
        checks++;
        if (n_wt != 1 || n_in != 1 || n_out != 1) begin
            errors++;
            $display("FAIL single_pulse_count got %0d/%0d/%0d exp 1/1/1", n_wt, n_in, n_out);
        end
        checks++;
        if (wt_c[0] != s + 1 || in_c[0] != s + 6 || out_c[0] != s + 42) begin
            errors++;
            $display("FAIL single_order got %0d/%0d/%0d exp %0d/%0d/%0d", wt_c[0], in_c[0], out_c[0], s + 1, s + 6, s + 42);
        end
        checks++;
        if (wt_a[0] !== 8'h10 || in_a[0] !== 8'h40 || out_a[0] !== 8'h80) begin
            errors++;
            $display("FAIL single_addr got %h/%h/%h exp 10/40/80", wt_a[0], in_a[0], out_a[0]);
        end
        checks++;
        if (out_c[0] - in_done_c != 32) begin
            errors++;
            $display("FAIL drain_gap got %0d exp 32", out_c[0] - in_done_c);
        end
        checks++;
        if (n_done != 1 || done_c != s + 48) begin
            errors++;
            $display("FAIL single_done got count %0d at %0d exp 1 at %0d", n_done, done_c, s + 48);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single_busy_after got %b exp 0", busy);
        end
        checks++;
        if (rows_enabled_num !== 4'd3 || cols_enabled_num !== 4'd5) begin
            errors++;
            $display("FAIL shape got %0d/%0d exp 3/5", rows_enabled_num, cols_enabled_num);
        end
    endtask

    task automatic test_multi_tile();
        int s;
        clear_log();
        launch(8'h10, 8'h40, 8'h80, 8'h04, 8'h04, 8'h08, 8'd2);
        s = start_c;
        run_until_done(400);
        tick();
        checks++;
        if (n_wt != 3 || wt_a[0] !== 8'h10 || wt_a[1] !== 8'h14 || wt_a[2] !== 8'h18) begin
            errors++;
            $display("FAIL multi_wt_addr got n%0d %h %h %h exp n3 10 14 18", n_wt, wt_a[0], wt_a[1], wt_a[2]);
        end
        checks++;
        if (in_a[0] !== 8'h40 || in_a[1] !== 8'h44 || in_a[2] !== 8'h48) begin
            errors++;
            $display("FAIL multi_in_addr got %h %h %h exp 40 44 48", in_a[0], in_a[1], in_a[2]);
        end
        checks++;
        if (out_a[0] !== 8'h80 || out_a[1] !== 8'h88 || out_a[2] !== 8'h90) begin
            errors++;
            $display("FAIL multi_out_addr got %h %h %h exp 80 88 90", out_a[0], out_a[1], out_a[2]);
        end
        checks++;
        if (ti[0] !== 8'd0 || ti[1] !== 8'd1 || ti[2] !== 8'd2) begin
            errors++;
            $display("FAIL multi_tile_idx got %0d %0d %0d exp 0 1 2", ti[0], ti[1], ti[2]);
        end
        checks++;
        if (n_done != 1 || done_c != s + 142) begin
            errors++;
            $display("FAIL multi_done got count %0d at %0d exp 1 at %0d", n_done, done_c, s + 142);
        end
    endtask

    task automatic test_wrap();
        clear_log();
        launch(8'h10, 8'h40, 8'hF8, 8'h00, 8'h00, 8'h08, 8'd1);
        run_until_done(300);
        tick();
        checks++;
        if (n_out != 2 || out_a[0] !== 8'hF8 || out_a[1] !== 8'h00) begin
            errors++;
            $display("FAIL wrap_addr got n%0d %h %h exp n2 f8 00", n_out, out_a[0], out_a[1]);
        end
    endtask

    task automatic test_stale_done();
        int s;
        clear_log();
        hold_wt = 1'b1;
        wt_done = 1'b1;
        repeat (3) tick();
        launch(8'h10, 8'h40, 8'h80, 8'h00, 8'h00, 8'h00, 8'd0);
        s = start_c;
        run_until_done(200);
        hold_wt = 1'b0;
        tick();
        checks++;
        if (in_c[0] - wt_c[0] != 4) begin
            errors++;
            $display("FAIL stale_gap got %0d exp 4", in_c[0] - wt_c[0]);
        end
        checks++;
        if (n_done != 1 || done_c != s + 47) begin
            errors++;
            $display("FAIL stale_done got count %0d at %0d exp 1 at %0d", n_done, done_c, s + 47);
        end
    endtask

    task automatic test_abort();
        int s;
        int k;
        clear_log();
        launch(8'h10, 8'h40, 8'h80, 8'h04, 8'h04, 8'h08, 8'd2);
        k = 0;
        while (n_in < 2 && k < 200) begin tick(); k++; end
        repeat (7) tick();   // second tile, now inside the drain window
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (aborted !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_pulse got aborted %b busy %b exp 1 0", aborted, busy);
        end
        repeat (80) tick();
        checks++;
        if (n_done != 0 || n_abt != 1 || n_wt != 2 || n_in != 2 || n_out != 1) begin
            errors++;
            $display("FAIL abort_quiet got done %0d abt %0d wt %0d in %0d out %0d exp 0 1 2 2 1",
                     n_done, n_abt, n_wt, n_in, n_out);
        end
        clear_log();
        launch(8'h20, 8'h50, 8'hA0, 8'h00, 8'h00, 8'h00, 8'd0);
        s = start_c;
        run_until_done(200);
        tick();
        checks++;
        if (wt_a[0] !== 8'h20 || in_a[0] !== 8'h50 || out_a[0] !== 8'hA0 || done_c != s + 48 || n_done != 1) begin
            errors++;
            $display("FAIL restart got %h/%h/%h done %0d at %0d exp 20/50/a0 done 1 at %0d",
                     wt_a[0], in_a[0], out_a[0], n_done, done_c, s + 48);
        end
    endtask

    task automatic test_reset_swait();
        int k;
        clear_log();
        launch(8'h10, 8'h40, 8'h80, 8'h00, 8'h00, 8'h00, 8'd0);
        k = 0;
        while (n_out < 1 && k < 200) begin tick(); k++; end
        tick();   // S_WAIT
        reset = 1'b0;
        #1;
        checks++;
        if ({wt_active, in_active, out_active, busy, done, aborted} !== 6'b0 ||
            {wt_addr, in_addr, out_addr, tile_idx, rows_enabled_num, cols_enabled_num} !== '0) begin
            errors++;
            $display("FAIL async_reset got busy %b addr %h/%h/%h exp all 0", busy, wt_addr, in_addr, out_addr);
        end
        repeat (2) tick();
        reset = 1'b1;
        clear_log();
        repeat (30) tick();
        checks++;
        if (n_wt + n_in + n_out != 0 || n_done != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle got pulses %0d done %0d busy %b exp 0 0 0",
                     n_wt + n_in + n_out, n_done, busy);
        end
    endtask

    initial begin
        clear_log();
        test_reset();
        test_single_tile();
        test_multi_tile();
        test_wrap();
        test_stale_done();
        test_abort();
        test_reset_swait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/tile_sequencer.md
Name: tile_sequencer

Overview:
- Top-level tile scheduler for the systolic array.
- Sequences three memory-master controllers through one phase each per tile, in order: weight load, then input feed, then output store.
- Each controller gets a one-cycle active pulse, a base address and the enabled row/column counts. The sequencer waits for that controller's done before starting the next phase.
- Loops over a programmed number of tiles, advancing every base address by a stride, then reports completion.

Parameters:
- ADDR_WIDTH, 8: width of every base address and stride.
- WIDTH_HEIGHT, 16: array dimension. Sets the count-field width CW = $clog2(WIDTH_HEIGHT) and the drain length.
- TILE_WIDTH, 8: width of the tile-count field.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin a job. Sampled only in IDLE.
- abort  in  1  cancel a job. Sampled in every state.
- wt_base, in_base, out_base  in  ADDR_WIDTH each  job base addresses. Captured on accept.
- wt_stride, in_stride, out_stride  in  ADDR_WIDTH each  per-tile address increments. Captured on accept.
- rows_num, cols_num  in  CW each  enabled rows/columns. Captured on accept.
- tile_num  in  TILE_WIDTH  tiles minus one (0 means one tile). Captured on accept.
- wt_done, in_done, out_done  in  1 each  controller done levels.
- wt_active, in_active, out_active  out  1 each  one-cycle phase-launch pulses.
- wt_addr, in_addr, out_addr  out  ADDR_WIDTH each  current tile base addresses.
- rows_enabled_num, cols_enabled_num  out  CW each  captured row/column counts.
- tile_idx  out  TILE_WIDTH  index of the current tile.
- busy  out  1  high from accept until return to IDLE.
- done  out  1  one-cycle pulse when the job finishes.
- aborted  out  1  one-cycle pulse when a job is cancelled.

Behaviour:
- Reset (reset=0, asynchronous):
  - state = IDLE.
  - Every output is 0 and every captured register is 0.
- All outputs are registered.
- States: IDLE, W_ISSUE, W_WAIT, F_ISSUE, F_WAIT, DRAIN, S_ISSUE, S_WAIT, NEXT, FINISH.
- IDLE: on start=1 and abort=0:
  - capture all job inputs;
  - clear tile_idx;
  - set busy=1;
  - go to W_ISSUE.
- X_ISSUE (X = W, F, S):
  - assert the matching *_active for exactly this one cycle;
  - load a 2-bit blank counter with 2;
  - go to X_WAIT.
- X_WAIT:
  - the matching *_done is ignored while the blank counter is nonzero, because a controller's done stays high from its previous run for up to two cycles after active;
  - once the counter reaches 0, the first cycle with *_done=1 advances the state.
  - Transitions: W_WAIT → F_ISSUE; F_WAIT → DRAIN; S_WAIT → NEXT.
  - There is no timeout.
- DRAIN:
  - waits exactly 2*WIDTH_HEIGHT-1 cycles to flush the array pipeline;
  - then goes to S_ISSUE.
- NEXT:
  - if tile_idx == tile_num, go to FINISH;
  - otherwise increment tile_idx, add each stride to its address register, and go to W_ISSUE.
  - NEXT lasts one cycle.
- FINISH: pulse done=1, set busy=0, go to IDLE.
- Address arithmetic: addr = addr + stride, modulo 2^ADDR_WIDTH. Wrap-around is silent, with no flag.
- While busy:
  - *_addr, rows_enabled_num and cols_enabled_num are stable, and change only in NEXT;
  - start is ignored.
- Abort:
  - abort=1 in any state other than IDLE: next cycle state = IDLE, busy=0, aborted=1 for one cycle, all *_active=0, done=0.
  - Abort wins over a simultaneous start, a *_done or the NEXT/FINISH decision.
  - abort in IDLE has no effect.
- A *_done for a phase that is not currently waited on is ignored.
- Minimum latency, from the start cycle to the done pulse, for one tile with every controller answering done at the first eligible cycle: 3*(1+3) + (2*WIDTH_HEIGHT-1) + 2 cycles.

Test Plan:
- Single tile (defaults: WIDTH_HEIGHT=16). Start with wt_base=0x10, in_base=0x40, out_base=0x80, rows_num=3, tile_num=0. Each done is returned 4 cycles after its active.
  - Required: exactly one pulse each of wt_active, in_active and out_active, in that order.
  - Required: addresses 0x10, 0x40 and 0x80 respectively.
  - Required: the gap from in_done to out_active is 31+1 cycles.
  - Required: one done pulse, then busy=0.
- Three tiles with wt_stride=4, in_stride=4, out_stride=8, starting from the bases above.
  - Required wt_addr sequence: 0x10, 0x14, 0x18.
  - Required out_addr sequence: 0x80, 0x88, 0x90.
  - Required: tile_idx runs 0, 1, 2, followed by a single done pulse.
- Wrap-around: out_base=0xF8, out_stride=8, tile_num=1 → out_addr 0xF8, then 0x00.
- Stale done: hold wt_done=1 continuously from before start.
  - Required: in_active fires no earlier than 3 cycles after wt_active.
- Abort: assert abort during DRAIN of tile 1.
  - Required: next cycle aborted=1 and busy=0; no done pulse; no further *_active pulses.
  - Then a fresh start runs correctly.
- Reset during S_WAIT: assert reset=0 asynchronously.
  - Required: all outputs go to 0 immediately.
  - Required: after release, no activity until start.
